// File: rtl/nn_pkg.sv
//==============================================================================
// Module : nn_pkg
// Brief  : Shared types and helpers for the pooling stage.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_GRANT = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } pool_state_e;

    localparam int c_MAX_DW = 32;

    // Signed maximum; on a tie the first argument (the incumbent) is kept.
    function automatic logic signed [c_MAX_DW-1:0] smax(
        input logic signed [c_MAX_DW-1:0] a,
        input logic signed [c_MAX_DW-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_addr_gen.sv
//==============================================================================
// Module : pool_addr_gen
// Brief  : Window/row/column walker producing the input-map read address.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pool_addr_gen #(
    parameter int DataSizeW   = 26,
    parameter int PoolW       = 2,
    parameter int PoolH       = 2,
    parameter int OutW        = 13,
    parameter int OutH        = 13,
    parameter int InAddrWidth = 10
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   i_clear,
    input  logic                   i_step,
    input  logic                   i_next_win,
    output logic [InAddrWidth-1:0] o_addr,
    output logic                   o_last_elem,
    output logic                   o_last_win
);
    import nn_pkg::*;

    localparam int c_CW = 16;
    localparam logic [InAddrWidth-1:0] c_ONE          = InAddrWidth'(1);
    localparam logic [InAddrWidth-1:0] c_ROW_STEP     = InAddrWidth'(DataSizeW);
    localparam logic [InAddrWidth-1:0] c_COL_STEP     = InAddrWidth'(PoolW);
    localparam logic [InAddrWidth-1:0] c_WIN_ROW_STEP = InAddrWidth'(PoolH * DataSizeW);

    logic [c_CW-1:0]        r_wx, r_wy, r_ox, r_oy;
    logic [InAddrWidth-1:0] r_row_base, r_win_base, r_line_base, r_addr;

    logic                   w_wx_last, w_wy_last, w_ox_last, w_oy_last;
    logic [InAddrWidth-1:0] w_next_line, w_next_col, w_next_row;

    assign w_wx_last   = (r_wx == c_CW'(PoolW - 1));
    assign w_wy_last   = (r_wy == c_CW'(PoolH - 1));
    assign w_ox_last   = (r_ox == c_CW'(OutW - 1));
    assign w_oy_last   = (r_oy == c_CW'(OutH - 1));
    assign w_next_line = r_line_base + c_ROW_STEP;
    assign w_next_col  = r_win_base + c_COL_STEP;
    assign w_next_row  = r_row_base + c_WIN_ROW_STEP;

    assign o_addr      = r_addr;
    assign o_last_elem = w_wx_last && w_wy_last;
    assign o_last_win  = w_ox_last && w_oy_last;

    // Addresses are built purely by accumulation; trailing partial columns/rows are never reached.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wx        <= '0;
            r_wy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_row_base  <= '0;
            r_win_base  <= '0;
            r_line_base <= '0;
            r_addr      <= '0;
        end else if (i_clear) begin
            r_wx        <= '0;
            r_wy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_row_base  <= '0;
            r_win_base  <= '0;
            r_line_base <= '0;
            r_addr      <= '0;
        end else if (i_step) begin
            if (w_wx_last) begin
                r_wx        <= '0;
                r_wy        <= r_wy + c_CW'(1);
                r_line_base <= w_next_line;
                r_addr      <= w_next_line;
            end else begin
                r_wx        <= r_wx + c_CW'(1);
                r_addr      <= r_addr + c_ONE;
            end
        end else if (i_next_win) begin
            r_wx <= '0;
            r_wy <= '0;
            if (w_ox_last) begin
                r_ox        <= '0;
                r_oy        <= r_oy + c_CW'(1);
                r_row_base  <= w_next_row;
                r_win_base  <= w_next_row;
                r_line_base <= w_next_row;
                r_addr      <= w_next_row;
            end else begin
                r_ox        <= r_ox + c_CW'(1);
                r_win_base  <= w_next_col;
                r_line_base <= w_next_col;
                r_addr      <= w_next_col;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/maxpool_2d.sv
//==============================================================================
// Module : maxpool_2d
// Brief  : Non-overlapping signed max-pool over an activation RAM, with handshakes.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module maxpool_2d #(
    parameter int DataSizeW    = 26,
    parameter int DataSizeH    = 26,
    parameter int PoolW        = 2,
    parameter int PoolH        = 2,
    parameter int DataWidth    = 8,
    parameter int ReluEn       = 0,
    parameter int OutW         = DataSizeW / PoolW,
    parameter int OutH         = DataSizeH / PoolH,
    parameter int InAddrWidth  = $clog2(DataSizeW * DataSizeH),
    parameter int OutAddrWidth = (OutW * OutH > 1) ? $clog2(OutW * OutH) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    output logic                    ack_o,
    output logic                    req_o,
    input  logic                    ack_i,
    input  logic                    ready_i,
    output logic                    ready_o,
    output logic                    in_actv_req_o,
    input  logic                    in_actv_grant_i,
    output logic [InAddrWidth-1:0]  actv_in_ram_addr,
    output logic                    actv_in_ram_we,
    input  logic [DataWidth-1:0]    actv_in_ram_din,
    output logic [OutAddrWidth-1:0] actv_out_ram_addr,
    output logic                    actv_out_ram_we,
    output logic [DataWidth-1:0]    actv_out_ram_dout
);
    import nn_pkg::*;

    localparam logic [OutAddrWidth-1:0] c_OADDR_ONE = OutAddrWidth'(1);

    pool_state_e             r_state;
    logic                    r_ack, r_req, r_ready, r_in_req, r_we;
    logic                    r_rd_vld, r_first;
    logic [OutAddrWidth-1:0] r_oaddr;
    logic [DataWidth-1:0]    r_dout, r_max;

    logic                    w_last_elem, w_last_win;
    logic                    w_clear, w_step, w_next_win;
    logic [DataWidth-1:0]    w_fold, w_result;

    assign w_clear    = (r_state == S_ACK);
    assign w_step     = (r_state == S_READ) && !w_last_elem;
    assign w_next_win = (r_state == S_WRITE) && !w_last_win;

    pool_addr_gen #(
        .DataSizeW   (DataSizeW),
        .PoolW       (PoolW),
        .PoolH       (PoolH),
        .OutW        (OutW),
        .OutH        (OutH),
        .InAddrWidth (InAddrWidth)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_clear     (w_clear),
        .i_step      (w_step),
        .i_next_win  (w_next_win),
        .o_addr      (actv_in_ram_addr),
        .o_last_elem (w_last_elem),
        .o_last_win  (w_last_win)
    );

    // The first element of each window seeds the max, so all-negative windows pool correctly.
    assign w_fold   = r_first ? actv_in_ram_din
                    : DataWidth'(smax(c_MAX_DW'($signed(r_max)), c_MAX_DW'($signed(actv_in_ram_din))));
    assign w_result = ((ReluEn != 0) && w_fold[DataWidth-1]) ? '0 : w_fold;

    assign ack_o             = r_ack;
    assign req_o             = r_req;
    assign ready_o           = r_ready;
    assign in_actv_req_o     = r_in_req;
    assign actv_in_ram_we    = 1'b0;
    assign actv_out_ram_addr = r_oaddr;
    assign actv_out_ram_we   = r_we;
    assign actv_out_ram_dout = r_dout;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_ack    <= 1'b0;
            r_req    <= 1'b0;
            r_ready  <= 1'b1;
            r_in_req <= 1'b0;
            r_we     <= 1'b0;
            r_rd_vld <= 1'b0;
            r_first  <= 1'b0;
            r_oaddr  <= '0;
            r_dout   <= '0;
            r_max    <= '0;
        end else begin
            r_ack    <= 1'b0;
            r_we     <= 1'b0;
            // Read data lags the address by one cycle.
            r_rd_vld <= (r_state == S_READ);
            if (r_rd_vld) begin
                r_max   <= w_fold;
                r_first <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (req_i && ready_i) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                S_ACK: begin
                    r_state  <= S_GRANT;
                    r_in_req <= 1'b1;
                    r_oaddr  <= '0;
                end
                S_GRANT: begin
                    if (in_actv_grant_i) begin
                        r_state <= S_READ;
                        r_first <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_last_elem) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                    r_we    <= 1'b1;
                    r_dout  <= w_result;
                    if (w_last_win) begin
                        r_in_req <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_last_win) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_first <= 1'b1;
                        r_oaddr <= r_oaddr + c_OADDR_ONE;
                    end
                end
                S_DONE: begin
                    if (ack_i) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2d.sv
//==============================================================================
// Module : tb_maxpool_2d
// Brief  : Directed bench: 4x4 plain, 4x4 ReLU and 5x5 instances run in lockstep.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_maxpool_2d;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic rdy_in = 1'b0;
    logic ackin = 1'b0;
    logic grant = 1'b0;
    logic clr = 1'b1;

    logic [2:0] ack_v, reqo_v, rdy_v, inreq_v, inwe_v, owe_v;
    logic [3:0] addr0, addr1;
    logic [4:0] addr2;
    logic [7:0] din0, din1, din2;
    logic [1:0] oaddr [3];
    logic [7:0] dout [3];

    logic [7:0] ram0 [16];
    logic [7:0] ram1 [16];
    logic [7:0] ram2 [25];
    logic [7:0] capd [3][8];
    int         capa [3][8];
    int         wc [3];
    logic       badaddr;

    int total = 0;
    int bad = 0;

    typedef struct {
        int              pat;
        int              gdly;
        int              nrdy;
        logic [0:3][7:0] e0;
        logic [0:3][7:0] e1;
        logic [0:3][7:0] e2;
    } vec_t;

    vec_t vecs [3];

    always #5 clk = ~clk;

    maxpool_2d #(.DataSizeW(4), .DataSizeH(4), .PoolW(2), .PoolH(2), .DataWidth(8), .ReluEn(0)) u_dut0 (
        .clk_i(clk), .reset_i(rst), .req_i(req), .ack_o(ack_v[0]), .req_o(reqo_v[0]), .ack_i(ackin),
        .ready_i(rdy_in), .ready_o(rdy_v[0]), .in_actv_req_o(inreq_v[0]), .in_actv_grant_i(grant),
        .actv_in_ram_addr(addr0), .actv_in_ram_we(inwe_v[0]), .actv_in_ram_din(din0),
        .actv_out_ram_addr(oaddr[0]), .actv_out_ram_we(owe_v[0]), .actv_out_ram_dout(dout[0])
    );

    maxpool_2d #(.DataSizeW(4), .DataSizeH(4), .PoolW(2), .PoolH(2), .DataWidth(8), .ReluEn(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .req_i(req), .ack_o(ack_v[1]), .req_o(reqo_v[1]), .ack_i(ackin),
        .ready_i(rdy_in), .ready_o(rdy_v[1]), .in_actv_req_o(inreq_v[1]), .in_actv_grant_i(grant),
        .actv_in_ram_addr(addr1), .actv_in_ram_we(inwe_v[1]), .actv_in_ram_din(din1),
        .actv_out_ram_addr(oaddr[1]), .actv_out_ram_we(owe_v[1]), .actv_out_ram_dout(dout[1])
    );

    maxpool_2d #(.DataSizeW(5), .DataSizeH(5), .PoolW(2), .PoolH(2), .DataWidth(8), .ReluEn(0)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .req_i(req), .ack_o(ack_v[2]), .req_o(reqo_v[2]), .ack_i(ackin),
        .ready_i(rdy_in), .ready_o(rdy_v[2]), .in_actv_req_o(inreq_v[2]), .in_actv_grant_i(grant),
        .actv_in_ram_addr(addr2), .actv_in_ram_we(inwe_v[2]), .actv_in_ram_din(din2),
        .actv_out_ram_addr(oaddr[2]), .actv_out_ram_we(owe_v[2]), .actv_out_ram_dout(dout[2])
    );

    always @(posedge clk) begin
        din0 <= ram0[addr0];
        din1 <= ram1[addr1];
        din2 <= (addr2 < 5'd25) ? ram2[addr2] : 8'h00;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 3; k++) wc[k] <= 0;
            badaddr <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (owe_v[k]) begin
                    if (wc[k] < 8) begin
                        capd[k][wc[k]] <= dout[k];
                        capa[k][wc[k]] <= int'(oaddr[k]);
                    end
                    wc[k] <= wc[k] + 1;
                end
            end
            if (inreq_v[2] && (((addr2 % 5'd5) == 5'd4) || (addr2 >= 5'd20))) badaddr <= 1'b1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input int pat);
        for (int a = 0; a < 16; a++) begin
            ram0[a] = (pat == 0) ? 8'(a) : 8'(-(a + 1));
            ram1[a] = (pat == 0) ? 8'(-(a + 1)) : 8'(a);
        end
        for (int a = 0; a < 25; a++) begin
            ram2[a] = ((a % 5 == 4) || (a / 5 == 4)) ? 8'd100 : 8'(a);
        end
    endtask

    task automatic run_job(input int gdly, input int nrdy);
        int n;
        logic seen;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = 1'b1;
        rdy_in = (nrdy == 0);
        seen = 1'b0;
        for (int i = 0; i < nrdy; i++) begin
            @(negedge clk);
            if (ack_v != 3'b000 || rdy_v != 3'b111) seen = 1'b1;
        end
        if (nrdy > 0) check("no_ack_while_not_ready", int'(seen), 0);
        rdy_in = 1'b1;
        @(negedge clk);
        check("ack_pulse", int'(ack_v), 7);
        check("ready_low_busy", int'(rdy_v), 0);
        req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", int'(ack_v), 0);
        check("in_req_high", int'(inreq_v), 7);
        for (int i = 0; i < gdly; i++) @(negedge clk);
        if (gdly > 0) begin
            check("addr_hold_pre_grant", int'(addr0), 0);
            check("no_write_pre_grant", wc[0], 0);
        end
        grant = 1'b1;
        n = 0;
        while (reqo_v != 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_o_timeout", int'(n < 200), 1);
        check("busy_cycles", n, 25);
        check("in_req_done", int'(inreq_v), 0);
        grant = 1'b0;
        repeat (2) @(negedge clk);
        check("req_o_held", int'(reqo_v), 7);
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        check("req_o_drop", int'(reqo_v), 0);
        check("ready_back", int'(rdy_v), 7);
    endtask

    task automatic cmp_results(input vec_t v);
        for (int k = 0; k < 3; k++) check("write_count", wc[k], 4);
        for (int i = 0; i < 4; i++) begin
            check("dout_plain4", int'($signed(capd[0][i])), int'($signed(v.e0[i])));
            check("dout_relu4", int'($signed(capd[1][i])), int'($signed(v.e1[i])));
            check("dout_plain5", int'($signed(capd[2][i])), int'($signed(v.e2[i])));
            check("oaddr_plain4", capa[0][i], i);
            check("oaddr_plain5", capa[2][i], i);
        end
        check("edge_addr_unread", int'(badaddr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic seen;

        vecs[0].pat = 0; vecs[0].gdly = 0;  vecs[0].nrdy = 0;
        vecs[0].e0 = {8'd5, 8'd7, 8'd13, 8'd15};
        vecs[0].e1 = {8'd0, 8'd0, 8'd0, 8'd0};
        vecs[0].e2 = {8'd6, 8'd8, 8'd16, 8'd18};
        vecs[1].pat = 1; vecs[1].gdly = 0;  vecs[1].nrdy = 0;
        vecs[1].e0 = {8'hFF, 8'hFD, 8'hF7, 8'hF5};
        vecs[1].e1 = {8'd5, 8'd7, 8'd13, 8'd15};
        vecs[1].e2 = {8'd6, 8'd8, 8'd16, 8'd18};
        vecs[2].pat = 0; vecs[2].gdly = 10; vecs[2].nrdy = 20;
        vecs[2].e0 = {8'd5, 8'd7, 8'd13, 8'd15};
        vecs[2].e1 = {8'd0, 8'd0, 8'd0, 8'd0};
        vecs[2].e2 = {8'd6, 8'd8, 8'd16, 8'd18};

        load(0);
        repeat (3) @(negedge clk);
        check("rst_ready", int'(rdy_v), 7);
        check("rst_ack", int'(ack_v), 0);
        check("rst_req", int'(reqo_v), 0);
        check("rst_in_req", int'(inreq_v), 0);
        check("rst_we", int'(owe_v | inwe_v), 0);
        check("rst_addr", int'(addr0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Upstream ack while idle must not start anything.
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", int'(reqo_v | ack_v), 0);

        for (int t = 0; t < 3; t++) begin
            load(vecs[t].pat);
            run_job(vecs[t].gdly, vecs[t].nrdy);
            cmp_results(vecs[t]);
        end

        // Asynchronous reset in the middle of the second window.
        load(0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req = 1'b1;
        rdy_in = 1'b1;
        @(negedge clk);
        req = 1'b0;
        grant = 1'b1;
        n = 0;
        while (wc[0] < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reset_reach", int'(n < 100), 1);
        @(negedge clk);
        check("mid_reset_busy_addr", int'(addr0), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", int'(rdy_v), 7);
        check("mid_rst_in_req", int'(inreq_v), 0);
        check("mid_rst_addr", int'(addr0), 0);
        check("mid_rst_oaddr", int'(oaddr[0]), 0);
        check("mid_rst_dout", int'(dout[0]), 0);
        check("mid_rst_we", int'(owe_v), 0);
        @(negedge clk);
        rst = 1'b0;
        grant = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (reqo_v != 3'b000 || ack_v != 3'b000) seen = 1'b1;
        end
        check("no_handshake_after_reset", int'(seen), 0);

        load(vecs[0].pat);
        run_job(0, 0);
        cmp_results(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
